// File: rtl/parity_pkg.sv
// parity_pkg: shared parity constants, FSM encoding and reference parity function
package parity_pkg;
    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;
    localparam int   MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    function automatic logic parity_of(input logic [MAX_W-1:0] data, input logic mode);
        return ^data ^ mode;
    endfunction
endpackage

// File: rtl/parity_calc.sv
// parity_calc: combinational parity of a DATA_W-bit word, inverted for odd mode
module parity_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    output logic              parity
);
    assign parity = ^data ^ mode;
endmodule

// File: rtl/parity_serializer.sv
// parity_serializer: serialises a parallel word bit by bit, then appends its parity bit
module parity_serializer
    import parity_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_mode,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              tx_ready,
    output logic              tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              mode_out,
    output logic [CNT_W-1:0]  counter,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shifted;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d, calc_par;
    logic              tx_data_q, tx_data_d, tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic              mode_q, mode_d, busy_q, busy_d;
    logic              load_fire, tx_fire, last_data, next_bit;

    parity_calc #(.DATA_W(DATA_W)) u_calc (
        .data   (load_data),
        .mode   (load_mode),
        .parity (calc_par)
    );

    // A new word may be taken while the parity bit leaves, giving gapless frames
    assign load_ready = (state_q == IDLE) | ((state_q == PARITY) & tx_ready);
    assign load_fire  = load_valid & load_ready;
    assign tx_fire    = tx_valid_q & tx_ready;
    assign last_data  = cnt_q == CNT_W'(DATA_W - 1);
    assign shifted    = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
    assign next_bit   = MSB_FIRST ? shifted[DATA_W-1] : shifted[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = load_fire                                   ? DATA   :
                  (state_q == DATA && tx_fire && last_data)   ? PARITY :
                  (state_q == PARITY && tx_fire)              ? IDLE   : state_q;
    end

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        if (load_fire) begin
            shift_d    = load_data;
            par_d      = calc_par;
            mode_d     = load_mode;
            cnt_d      = '0;
            tx_data_d  = MSB_FIRST ? load_data[DATA_W-1] : load_data[0];
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            busy_d     = 1'b1;
        end else if (tx_fire && state_q == DATA) begin
            shift_d   = shifted;
            cnt_d     = cnt_q + CNT_W'(1);
            tx_data_d = last_data ? par_q : next_bit;
            tx_last_d = last_data;
        end else if (tx_fire && state_q == PARITY) begin
            cnt_d      = '0;
            tx_data_d  = 1'b0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            busy_d     = 1'b0;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign mode_out = mode_q;
    assign counter  = cnt_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer: directed frames plus random scoreboard on MSB- and LSB-first instances
module tb_parity_serializer;
    import parity_pkg::*;

    logic       clk = 1'b0, reset = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_mode = 1'b0, load_valid = 1'b0, tx_ready = 1'b1;
    logic       load_ready, tx_data, tx_valid, tx_last, mode_out, busy;
    logic [3:0] counter;
    logic       l_ready, l_data, l_valid, l_last, l_mode, l_busy;
    logic [3:0] l_cnt;
    int         total = 0, bad = 0;

    logic [8:0] qm[$], ql[$];
    logic [8:0] e;
    logic [7:0] wm, wl;
    int         nm, nl, acc, dm, dl, cyc;
    logic       taken;

    always #5 clk = ~clk;

    parity_serializer #(.DATA_W(8), .CNT_W(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_mode(load_mode),
        .load_valid(load_valid), .load_ready(load_ready), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .mode_out(mode_out), .counter(counter), .busy(busy)
    );

    parity_serializer #(.DATA_W(8), .CNT_W(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load_data(load_data), .load_mode(load_mode),
        .load_valid(load_valid), .load_ready(l_ready), .tx_ready(tx_ready),
        .tx_data(l_data), .tx_valid(l_valid), .tx_last(l_last),
        .mode_out(l_mode), .counter(l_cnt), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic start(input logic [7:0] d, input logic m);
        load_data = d; load_mode = m; load_valid = 1'b1;
        #1;
        chk("ld_rdy", load_ready, 1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic bits(input logic [7:0] d, input logic m, input logic p, input int st_at,
                        input int st_len, input logic chain, input logic [7:0] nd, input logic nmode);
        for (int i = 0; i < 9; i++) begin
            logic eb;
            eb = (i < 8) ? d[7-i] : p;
            chk("bit_msb", tx_data, eb);
            chk("bit_lsb", l_data, (i < 8) ? d[i] : p);
            chk("cnt", counter, (i < 8) ? i : 8);
            chk("last", tx_last, i == 8);
            chk("valid", tx_valid, 1);
            chk("mode", mode_out, m);
            chk("busy", busy, 1);
            chk("rdy_mid", load_ready, i == 8);
            if (i == st_at) begin
                tx_ready = 1'b0;
                repeat (st_len) begin
                    @(negedge clk);
                    chk("hold_bit", tx_data, eb);
                    chk("hold_cnt", counter, i);
                    chk("hold_vld", tx_valid, 1);
                    chk("hold_rdy", load_ready, 0);
                end
                tx_ready = 1'b1;
            end
            if (i == 8 && chain) begin
                load_data = nd; load_mode = nmode; load_valid = 1'b1;
                #1;
                chk("b2b_rdy", load_ready, 1);
            end
            @(negedge clk);
        end
        if (chain) load_valid = 1'b0;
        else begin
            chk("idle_vld", tx_valid, 0);
            chk("idle_last", tx_last, 0);
            chk("idle_busy", busy, 0);
            chk("idle_cnt", counter, 0);
            chk("idle_rdy", load_ready, 1);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_vld", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", counter, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_mode", mode_out, 0);
        @(negedge clk);
        reset = 1'b0;

        start(8'hD1, 1'b0);
        bits(8'hD1, 1'b0, 1'b0, -1, 0, 1'b0, 8'h00, 1'b0);
        start(8'hD1, 1'b1);
        bits(8'hD1, 1'b1, 1'b1, -1, 0, 1'b0, 8'h00, 1'b0);

        start(8'hFF, 1'b0);
        bits(8'hFF, 1'b0, 1'b0, -1, 0, 1'b1, 8'h01, 1'b1);
        bits(8'h01, 1'b1, 1'b0, -1, 0, 1'b0, 8'h00, 1'b0);

        start(8'hA5, 1'b0);
        bits(8'hA5, 1'b0, 1'b0, 4, 3, 1'b0, 8'h00, 1'b0);

        start(8'hF0, 1'b1);
        repeat (3) @(negedge clk);
        chk("pre_rst_cnt", counter, 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", counter, 0);
        chk("mid_rst_mode", mode_out, 0);
        chk("mid_rst_lvld", l_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        start(8'h00, 1'b0);
        bits(8'h00, 1'b0, 1'b0, -1, 0, 1'b0, 8'h00, 1'b0);

        wm = '0; wl = '0; nm = 0; nl = 0; acc = 0; dm = 0; dl = 0; cyc = 0; taken = 1'b0;
        while ((dm < 200 || dl < 200) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (taken) load_valid = 1'b0;
            tx_ready = ($urandom_range(3) != 0);
            if (!load_valid && acc < 200 && $urandom_range(2) != 0) begin
                load_data = 8'($urandom);
                load_mode = 1'($urandom);
                load_valid = 1'b1;
            end
            #1;
            taken = load_valid && load_ready;
            if (taken) begin
                acc++;
                qm.push_back({load_mode, load_data});
                ql.push_back({load_mode, load_data});
            end
            if (tx_valid && tx_ready) begin
                if (!tx_last) begin
                    wm = {wm[6:0], tx_data};
                    nm++;
                end else if (qm.size() == 0) chk("sb_empty_m", qm.size(), 1);
                else begin
                    e = qm.pop_front();
                    chk("r_word_m", wm, e[7:0]);
                    chk("r_nbit_m", nm, 8);
                    chk("r_par_m", tx_data, parity_of(64'(e[7:0]), e[8]));
                    chk("r_mode_m", mode_out, e[8]);
                    wm = '0; nm = 0; dm++;
                end
            end
            if (l_valid && tx_ready) begin
                if (!l_last) begin
                    wl = {l_data, wl[7:1]};
                    nl++;
                end else if (ql.size() == 0) chk("sb_empty_l", ql.size(), 1);
                else begin
                    e = ql.pop_front();
                    chk("r_word_l", wl, e[7:0]);
                    chk("r_nbit_l", nl, 8);
                    chk("r_par_l", l_data, parity_of(64'(e[7:0]), e[8]));
                    chk("r_mode_l", l_mode, e[8]);
                    wl = '0; nl = 0; dl++;
                end
            end
        end
        chk("rnd_frames_m", dm, 200);
        chk("rnd_frames_l", dl, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parity_serializer.md
Name: parity_serializer

Overview:
- Transmit-side counterpart of the team's serial parity checker.
- Accepts a parallel data word plus a parity mode through a valid/ready handshake.
- Serialises the word one bit per cycle onto a tx_data/tx_valid stream, then appends one generated parity bit.
- Output stream is directly compatible with the checker's data_in/valid/mode inputs.

Parameters:
- DATA_W, 8, data bits per frame (frame length = DATA_W + 1 bits).
- CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > DATA_W.
- MSB_FIRST, 1, bit order: 1 = MSB first, 0 = LSB first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load_data  input  DATA_W  word to transmit.
- load_mode  input  1  parity mode: 0 = even, 1 = odd.
- load_valid  input  1  load_data/load_mode valid.
- load_ready  output  1  block can accept a word this cycle.
- tx_ready  input  1  downstream accepts the current bit; tie to 1 when no backpressure.
- tx_data  output  1  serial bit.
- tx_valid  output  1  tx_data valid.
- tx_last  output  1  current bit is the parity bit.
- mode_out  output  1  mode of the frame in flight; drives the checker's mode input.
- counter  output  CNT_W  bits of the current frame already transferred.
- busy  output  1  frame in flight.

Behaviour:
- States: IDLE, DATA, PARITY.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - tx_data, tx_valid, tx_last, mode_out, busy = 0; counter = 0.
  - Shift register and parity register cleared.
  - No transfer is accepted while reset is high.
- load_ready is combinational: (state==IDLE) | (state==PARITY & tx_ready).
- Load transfer occurs on a rising edge with load_valid & load_ready:
  - Capture load_data into the shift register.
  - Capture load_mode into mode_out.
  - Parity bit = XOR-reduce(load_data) XOR load_mode.
  - Next state = DATA, counter = 0, tx_valid = 1, busy = 1.
  - tx_data = first bit per MSB_FIRST.
  - Latency: first bit appears one cycle after acceptance.
- Bit transfer occurs on a rising edge with tx_valid & tx_ready.
- DATA state, on each bit transfer:
  - Shift to the next bit; counter increments.
  - After bit DATA_W is transferred (counter reaches DATA_W): state = PARITY, tx_data = parity bit, tx_last = 1.
- PARITY state, on transfer of the parity bit:
  - counter is not incremented past DATA_W.
  - If a load transfer occurs in the same cycle: go directly to DATA with the new word and counter = 0 (zero-gap back-to-back frames).
  - Otherwise: go to IDLE with tx_valid = 0, tx_last = 0, busy = 0, counter = 0.
- tx_ready low: tx_data, tx_valid, tx_last and counter all hold, with no limit on stall length.
- load_data and load_mode changing mid-frame have no effect; mode_out is stable for the whole frame.
- Reset mid-frame: frame discarded, no partial parity emitted, outputs return to reset values immediately.
- Registered outputs: tx_data, tx_valid, tx_last, mode_out, counter, busy. No combinational path from load_* to tx_*.

Decomposition:
- Shared package parity_pkg:
  - MODE_EVEN = 1'b0, MODE_ODD = 1'b1.
  - State encoding constants (IDLE, DATA, PARITY).
  - parity_of(data, mode) function, reused by the checker and by bench scoreboards.
- One natural sub-module, parity_calc: combinational XOR-reduce plus mode inversion, DATA_W-parameterised. The serializer instantiates it at the load boundary.
- Shift/count FSM stays in parity_serializer.

Test Plan:
- Even parity, MSB first: reset 10 ns, load 8'hD1 with mode 0, tx_ready = 1 -> tx_data 1,1,0,1,0,0,0,1 on cycles 1–8 after acceptance, counter 0..7. Cycle 9: tx_data = 0, tx_last = 1. Then IDLE, load_ready = 1.
- Odd parity: same stimulus with mode 1 -> identical data bits, parity bit = 1. mode_out = 1 throughout; busy drops after the 9th bit.
- Back-to-back: 8'hFF/even (parity 0), then 8'h01/odd presented during the first frame's parity cycle -> 18 consecutive tx_valid cycles with no gap. Second parity bit = 0, mode_out switches 0->1 at the frame boundary.
- Backpressure: 8'hA5/even, tx_ready low for 3 cycles while counter = 4 -> tx_data and counter held at 4, frame spans 12 cycles, parity bit = 0.
- Reset mid-frame: assert reset after 3 bits of 8'hF0 -> tx_valid, busy and counter go to 0 without waiting for a clock edge. After release, load 8'h00/even -> eight 0s, then parity 0.
- Random regression: 200 frames with random data, mode and tx_ready gaps (MSB_FIRST = 0 and 1). Scoreboard reassembles the bits and checks parity_of() -> zero mismatches.
